// File: rtl/lutram_fifo_pkg.sv
// Shared core configuration for the LUT-RAM FIFO: default depth and debug-flag enable.
package lutram_fifo_pkg;

    localparam int FIFO_DEPTH_DEFAULT  = 4;
    localparam bit FIFO_DEBUG_FLAGS_EN = 1'b1;

endpackage

// File: rtl/lut_ram.sv
// Distributed RAM: one synchronous write port, READ_PORTS asynchronous read ports.
module lut_ram #(
    parameter int DEPTH      = 4,
    parameter int WIDTH      = 32,
    parameter int READ_PORTS = 1,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i [READ_PORTS],
    output logic [WIDTH-1:0] rdata_o [READ_PORTS]
);

    // Contents are intentionally not reset so the array maps onto LUT storage.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
        assign rdata_o[g] = mem_q[raddr_i[g]];
    end

endmodule

// File: rtl/lutram_fifo.sv
// First-word fall-through FIFO over a lut_ram; pointers, occupancy and sticky error flags live here.
module lutram_fifo
    import lutram_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             full_q,   valid_q;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;
    logic             push_ok,  pop_ok;
    logic [AW-1:0]    raddr [1];
    logic [WIDTH-1:0] rdata [1];

    // Acceptance uses the registered flags, so a full FIFO drops the push even when a pop is
    // also accepted, and an empty FIFO ignores the pop even when a push is accepted.
    assign push_ok = push && !full_q  && !rst;
    assign pop_ok  = pop  &&  valid_q && !rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (FIFO_DEBUG_FLAGS_EN && push && full_q)   ovf_d = 1'b1;
        if (FIFO_DEBUG_FLAGS_EN && pop  && !valid_q) unf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            valid_q  <= (count_d != '0);
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign raddr[0] = rd_ptr_q;

    lut_ram #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .READ_PORTS (1)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign data_out  = rdata[0];
    assign full      = full_q;
    assign valid     = valid_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_lutram_fifo.sv
// Self-checking bench for lutram_fifo (WIDTH=8, DEPTH=4): directed scenarios then random traffic vs a queue model.
module tb_lutram_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             valid;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    lutram_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .data_in   (data_in),
        .full      (full),
        .pop       (pop),
        .data_out  (data_out),
        .valid     (valid),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count",     32'(count),     32'(mq.size()));
        chk("valid",     32'(valid),     32'(mq.size() != 0));
        chk("full",      32'(full),      32'(mq.size() == DEPTH));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        if (mq.size() != 0) chk("data_out", 32'(data_out), 32'(mq[0]));
    endtask

    // Drive one cycle, advance the model by the FIFO rules, then check 1ns after the edge.
    task automatic step(input bit r, input bit pu, input bit po, input logic [7:0] d);
        bit acc_push;
        bit acc_pop;
        rst = r; push = pu; pop = po; data_in = d;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            acc_push = pu && (mq.size() < DEPTH);
            acc_pop  = po && (mq.size() > 0);
            if (pu && !acc_push) m_ovf = 1'b1;
            if (po && !acc_pop)  m_unf = 1'b1;
            if (acc_pop)  void'(mq.pop_front());
            if (acc_push) mq.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        int pbias;
        int obias;
        rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;

        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);

        step(0, 1, 0, 8'h11);
        chk("first_push_dout", 32'(data_out), 32'h11);
        chk("first_push_cnt",  32'(count),    32'd1);
        step(0, 0, 1, 8'h00);

        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'hA0 + i));
        chk("fill_full", 32'(full),  32'd1);
        chk("fill_cnt",  32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(data_out), 32'(8'(8'hA0 + i)));
            step(0, 0, 1, 8'h00);
        end
        chk("drained_valid", 32'(valid), 32'd0);

        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'hB0 + i));
        step(0, 1, 0, 8'hFF);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(count),    32'd4);
        step(0, 1, 1, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_no_ff", 32'(data_out == 8'hFF || data_out == 8'hFE), 32'd0);
            step(0, 0, 1, 8'h00);
        end

        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_cnt", 32'(count),     32'd0);
        step(0, 1, 1, 8'h5A);
        chk("unf_push_only", 32'(data_out), 32'h5A);
        step(0, 0, 1, 8'h00);

        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h01);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 8'(i + 2));
            chk("stream_cnt", 32'(count), 32'd2);
        end
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);

        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'hC0 + i));
        step(0, 0, 1, 8'h00);
        chk("pre_rst_cnt", 32'(count), 32'd3);
        step(1, 1, 0, 8'h77);
        chk("rst_cnt",   32'(count),     32'd0);
        chk("rst_valid", 32'(valid),     32'd0);
        chk("rst_full",  32'(full),      32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_unf",   32'(underflow), 32'd0);

        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                pbias = int'($urandom_range(90, 10));
                obias = int'($urandom_range(90, 10));
            end
            step($urandom_range(59) == 0,
                 int'($urandom_range(99)) < pbias,
                 int'($urandom_range(99)) < obias,
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/lutram_fifo.md
LUTRAM_FIFO -- requirements
Module: lutram_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data bits per entry.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of entries; it must be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port push, input, 1 bit: producer requests a write this cycle.
REQ-006 SHALL have port data_in, input, WIDTH bits: write data, sampled when a push is accepted.
REQ-007 SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-008 SHALL have port pop, input, 1 bit: consumer takes the head entry this cycle.
REQ-009 SHALL have port data_out, output, WIDTH bits: head entry, valid whenever valid is high.
REQ-010 SHALL have port valid, output, 1 bit: high when count is nonzero.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy, 0 to DEPTH.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag set by a push while full.
REQ-013 SHALL have port underflow, output, 1 bit: sticky flag set by a pop while not valid.

Function
REQ-014 SHALL accept a push only when full is low; an accepted push writes data_in at write_index and increments write_index modulo DEPTH.
REQ-015 SHALL accept a pop only when valid is high; an accepted pop increments read_index modulo DEPTH.
REQ-016 SHALL drive data_out combinationally from the storage at read_index (first-word fall-through); the entry is visible 1 cycle after its push is accepted.
REQ-017 SHALL update count as count + accepted_push - accepted_pop each cycle, with no wrap.
REQ-018 SHALL register full and valid from the next-state count, so both are glitch-free outputs of flops.
REQ-019 When push and pop are both accepted in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-020 When full, a simultaneous push and pop SHALL accept the pop only; the push SHALL be dropped and overflow SHALL be set.
REQ-021 When empty, a simultaneous push and pop SHALL accept the push only; underflow SHALL be set.
REQ-022 The index wrap from DEPTH-1 to 0 SHALL have no bubble; back-to-back pushes and pops SHALL sustain 1 entry per cycle.
REQ-023 overflow and underflow SHALL stay set until rst; rejected operations SHALL alter neither the pointers nor storage.

Reset
REQ-024 On rst, the block SHALL clear write_index, read_index, count, full, valid, overflow and underflow on the next edge.
REQ-025 Storage contents SHALL NOT be reset; data_out is don't-care while valid is low.
REQ-026 A push or pop presented in a cycle where rst is high SHALL be discarded, including mid-stream, and the FIFO SHALL read empty the following cycle.

Structure
REQ-027 The default DEPTH and the FIFO debug-flag enable constant SHALL live in the shared core configuration package; no new typedefs are required.
REQ-028 Storage SHALL be one instance of lut_ram with DEPTH entries, WIDTH bits, READ_PORTS=1, waddr=write_index, raddr[0]=read_index, and ram_write=accepted push.
REQ-029 Pointer, count and flag logic SHALL stay in lutram_fifo; the implementation SHALL be 120-400 lines.

Verification (WIDTH=8, DEPTH=4)
REQ-030 Reset, then push 0x11 in one cycle -> next cycle valid=1, count=1, data_out=0x11.
REQ-031 Push 0xA0..0xA3 on consecutive cycles -> full=1 and count=4 after the 4th; pops return 0xA0..0xA3 in order, then valid=0.
REQ-032 Fill to 4, then push 0xFF -> overflow=1, count=4, and draining yields no 0xFF.
REQ-033 Pop while empty -> underflow=1, count=0, pointers unchanged.
REQ-034 Hold 2 entries and run 10 cycles of push+pop with an incrementing pattern -> count stays 2, pointers wrap, and data emerges in order with no gaps.
REQ-035 With 3 entries, assert rst for 1 cycle while also pushing -> next cycle count=0, valid=0, full=0, flags=0.
